skid_buffer_round_robin_arbiter: RTL and testbench



---
 rtl/skid_buffer_round_robin_arbiter_pkg.sv | 14 +
 rtl/skid_buffer_round_robin_arbiter_skid_buffer.sv | 56 +++++
 rtl/skid_buffer_round_robin_arbiter.sv | 99 +++++++++
 tb/tb_skid_buffer_round_robin_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/skid_buffer_round_robin_arbiter_pkg.sv
// Shared constants and helpers for the skid-buffered round-robin arbiter.
// Each upstream port is decoupled by a two-entry skid buffer.
package skid_buffer_round_robin_arbiter_pkg;

  localparam int SKID_DEPTH = 2;

  // Width of a port number; a single port still needs one bit.
  function automatic int index_width(input int requesters);
    int width_v;
    width_v = (requesters > 1) ? $clog2(requesters) : 1;
    return width_v;
  endfunction

endpackage

// File: rtl/skid_buffer_round_robin_arbiter_skid_buffer.sv
// Two-entry skid buffer: registered full/empty flags, FIFO order, and
// simultaneous read and write in the same cycle.
module skid_buffer
  import skid_buffer_round_robin_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] write_data,
  output logic             full,
  input  logic             read_enable,
  output logic [WIDTH-1:0] read_data,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [SKID_DEPTH];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             do_write_s;
  logic             do_read_s;

  assign do_write_s = write_enable & ~full;
  assign do_read_s  = read_enable & ~empty;

  // Storage, pointers and occupancy; reset is sampled on the clock edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_write_s) begin
        mem_r[wr_ptr_r] <= write_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_read_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_write_s, do_read_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign full      = (count_r == 2'(SKID_DEPTH));
  assign empty     = (count_r == 2'd0);
  assign read_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/skid_buffer_round_robin_arbiter.sv
// Shares one downstream write channel between REQUESTERS skid-buffered
// upstream writers using a wrap-around round-robin scan.
module skid_buffer_round_robin_arbiter
  import skid_buffer_round_robin_arbiter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int REQUESTERS = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [REQUESTERS-1:0]               upstream_write_enable,
  input  logic [REQUESTERS*WIDTH-1:0]         upstream_write_data,
  output logic [REQUESTERS-1:0]               upstream_full,
  output logic                                downstream_write_enable,
  output logic [WIDTH-1:0]                    downstream_write_data,
  output logic [index_width(REQUESTERS)-1:0]  downstream_write_index,
  input  logic                                downstream_full,
  output logic                                idle
);

  localparam int INDEX_WIDTH = index_width(REQUESTERS);

  logic [REQUESTERS-1:0]  full_s;
  logic [REQUESTERS-1:0]  empty_s;
  logic [REQUESTERS-1:0]  request_s;
  logic [REQUESTERS-1:0]  grant_s;
  logic [WIDTH-1:0]       read_data_s [REQUESTERS];
  logic [WIDTH-1:0]       data_s;
  logic [INDEX_WIDTH-1:0] pointer_r;
  logic [INDEX_WIDTH-1:0] pointer_next_s;
  logic [INDEX_WIDTH-1:0] grant_index_s;

  for (genvar i = 0; i < REQUESTERS; i++) begin : g_port
    skid_buffer #(.WIDTH(WIDTH)) u_skid (
      .clock        (clock),
      .resetn       (~reset),
      .write_enable (upstream_write_enable[i]),
      .write_data   (upstream_write_data[i*WIDTH +: WIDTH]),
      .full         (full_s[i]),
      .read_enable  (grant_s[i]),
      .read_data    (read_data_s[i]),
      .empty        (empty_s[i])
    );
  end

  assign request_s = ~empty_s;

  // First requester at or after the pointer wins; nothing while downstream is full.
  always_comb begin
    logic                   found_v;
    logic                   take_v;
    int                     sum_v;
    logic [INDEX_WIDTH-1:0] idx_v;
    grant_s       = '0;
    grant_index_s = '0;
    found_v       = 1'b0;
    take_v        = 1'b0;
    sum_v         = 0;
    idx_v         = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      sum_v          = int'(pointer_r) + k;
      sum_v          = (sum_v >= REQUESTERS) ? sum_v - REQUESTERS : sum_v;
      idx_v          = INDEX_WIDTH'(sum_v);
      take_v         = ~downstream_full & ~found_v & request_s[idx_v];
      grant_s[idx_v] = grant_s[idx_v] | take_v;
      grant_index_s  = take_v ? idx_v : grant_index_s;
      found_v        = found_v | take_v;
    end
  end

  // AND-OR mux of the granted buffer's head; zero when nothing is granted.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      data_s = data_s | (read_data_s[i] & {WIDTH{grant_s[i]}});
    end
  end

  assign pointer_next_s = (grant_index_s == INDEX_WIDTH'(REQUESTERS - 1))
                        ? '0 : grant_index_s + INDEX_WIDTH'(1);

  // Pointer moves past the winner only on a granted cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pointer_r <= '0;
    end else if (|grant_s) begin
      pointer_r <= pointer_next_s;
    end else begin
      pointer_r <= pointer_r;
    end
  end

  assign upstream_full           = full_s;
  assign downstream_write_enable = |grant_s;
  assign downstream_write_data   = data_s;
  assign downstream_write_index  = grant_index_s;
  assign idle                    = &empty_s;

endmodule

// File: tb/tb_skid_buffer_round_robin_arbiter.sv
// Scoreboard bench: per-port queues filled on upstream writes and drained
// against every downstream transfer, plus directed ordering checks.
module tb_skid_buffer_round_robin_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  upstream_write_enable = 4'b0000;
  logic [31:0] upstream_write_data = 32'h0000_0000;
  logic [3:0]  upstream_full;
  logic        downstream_write_enable;
  logic [7:0]  downstream_write_data;
  logic [1:0]  downstream_write_index;
  logic        downstream_full = 1'b1;
  logic        idle;

  int error_count = 0;
  int check_count = 0;

  logic [7:0] sb_q [4][$];
  logic       last_we;
  logic [1:0] last_idx;
  logic [7:0] last_data;
  int         grant_count [4];

  skid_buffer_round_robin_arbiter #(.WIDTH(8), .REQUESTERS(4)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .upstream_write_enable   (upstream_write_enable),
    .upstream_write_data     (upstream_write_data),
    .upstream_full           (upstream_full),
    .downstream_write_enable (downstream_write_enable),
    .downstream_write_data   (downstream_write_data),
    .downstream_write_index  (downstream_write_index),
    .downstream_full         (downstream_full),
    .idle                    (idle)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One cycle: drive at the falling edge, check the transfer, record writes.
  task automatic drive_cycle(input logic [3:0] we, input logic [31:0] data, input logic dfull);
    logic [31:0] exp_v;
    @(negedge clock);
    upstream_write_enable = we & ~upstream_full;
    upstream_write_data   = data;
    downstream_full       = dfull;
    #1;
    last_we   = downstream_write_enable;
    last_idx  = downstream_write_index;
    last_data = downstream_write_data;
    if (downstream_write_enable) begin
      grant_count[downstream_write_index]++;
      if (sb_q[downstream_write_index].size() > 0)
        exp_v = {24'h0, sb_q[downstream_write_index].pop_front()};
      else
        exp_v = 32'hFFFF_FFFF;
      check_value("sb_data", {24'h0, downstream_write_data}, exp_v);
    end else begin
      check_value("idle_data_index", {22'h0, downstream_write_index, downstream_write_data}, 32'h0);
    end
    if (dfull) check_value("no_grant_when_full", {31'h0, downstream_write_enable}, 32'h0);
    for (int i = 0; i < 4; i++)
      if (upstream_write_enable[i]) sb_q[i].push_back(data[i*8 +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    upstream_write_enable = 4'b0000;
    downstream_full = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) sb_q[i].delete();
  endtask

  initial begin
    int exp_rr;
    logic [3:0] we_v;

    // Test 1: reset state
    do_reset();
    drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("rst_idle", {31'h0, idle}, 32'h1);
    check_value("rst_full", {28'h0, upstream_full}, 32'h0);
    check_value("rst_we", {31'h0, last_we}, 32'h0);

    // Test 2: two writes to port 2 while downstream is full
    drive_cycle(4'b0100, 32'h00AA_0000, 1'b1);
    drive_cycle(4'b0100, 32'h0055_0000, 1'b1);
    drive_cycle(4'b0000, 32'h0, 1'b1);
    check_value("t2_full", {28'h0, upstream_full}, 32'h4);
    check_value("t2_idle", {31'h0, idle}, 32'h0);
    drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("t2_first", {23'h0, last_we, last_idx, last_data}, {23'h0, 1'b1, 2'd2, 8'hAA});
    drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("t2_second", {23'h0, last_we, last_idx, last_data}, {23'h0, 1'b1, 2'd2, 8'h55});
    drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("t2_idle_after", {31'h0, idle}, 32'h1);

    // Test 3: all ports saturated, strict rotation from pointer 0
    do_reset();
    exp_rr = 0;
    for (int i = 0; i < 4; i++) grant_count[i] = 0;
    for (int c = 0; c < 100; c++) begin
      drive_cycle(4'b1111, $urandom, 1'b0);
      if (last_we) begin
        check_value("t3_rr_index", {30'h0, last_idx}, exp_rr);
        exp_rr = (exp_rr + 1) % 4;
      end
    end
    for (int i = 0; i < 4; i++)
      check_value("t3_share", {31'h0, (grant_count[i] >= 24 && grant_count[i] <= 26)}, 32'h1);
    for (int c = 0; c < 12; c++) drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("t3_drained", {31'h0, idle}, 32'h1);

    // Test 4: port 3 streams 0..99 with no backpressure
    for (int c = 0; c <= 100; c++) begin
      drive_cycle((c < 100) ? 4'b1000 : 4'b0000, {8'(c), 24'h0}, 1'b0);
      check_value("t4_not_full", {31'h0, upstream_full[3]}, 32'h0);
      if (c > 0)
        check_value("t4_stream", {22'h0, last_we, last_idx, last_data}, {22'h0, 1'b1, 2'd3, 8'(c - 1)});
    end
    drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("t4_idle", {31'h0, idle}, 32'h1);

    // Test 5: pointer parked at 2 by a port-1 grant, then ports 1 and 3 pending
    drive_cycle(4'b0010, 32'h0000_1100, 1'b0);
    drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("t5_setup", {30'h0, last_idx}, 32'h1);
    drive_cycle(4'b1010, 32'h3300_1200, 1'b1);
    drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("t5_wrap_first", {29'h0, last_we, last_idx}, {29'h0, 1'b1, 2'd3});
    drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("t5_wrap_second", {29'h0, last_we, last_idx}, {29'h0, 1'b1, 2'd1});

    // Test 6: random traffic and backpressure with a mid-run reset
    for (int c = 0; c < 1000; c++) begin
      if (c == 500) do_reset();
      we_v = 4'($urandom);
      drive_cycle(we_v, $urandom, ($urandom_range(0, 9) < 3));
    end
    for (int c = 0; c < 20; c++) drive_cycle(4'b0000, 32'h0, 1'b0);
    check_value("t6_idle", {31'h0, idle}, 32'h1);
    for (int i = 0; i < 4; i++)
      check_value("t6_sb_empty", sb_q[i].size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
